// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//
// Direct-mapped branch target buffer. Each entry holds a valid bit, a tag,
// a branch target and a CTR_BITS-wide saturating direction counter. The
// IF stage reads the table combinationally to get a next-PC prediction.
// The ID stage reports resolved conditional branches. Those reports train
// the table on the next clock edge and raise a combinational mispredict
// flush that carries the corrected PC.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   lu_valid, lu_pc   IF lookup qualifier and fetch PC
//   pred_hit          a valid entry with a matching tag was found
//   pred_taken        the prediction is taken (counter MSB set on a hit)
//   pred_target       predicted next PC (stored target or lu_pc+4)
//   upd_*             ID-stage resolution: PC, outcome, target, and the
//                     prediction that was carried down the pipe
//   mispredict        flush request for the current resolution
//   correct_pc        redirect PC (upd_target if taken, else upd_pc+4)
//   stat_lookups      saturating count of lu_valid cycles
//   stat_mispredicts  saturating count of mispredict cycles
//
// Qualifier semantics: lu_valid and upd_valid are single-cycle qualifiers
// with no back-pressure. Each cycle in which one of them is high is one
// transaction, and the block always accepts it. The lookup outputs are
// driven every cycle whatever the state of lu_valid. lu_valid only gates
// the statistics.

module branch_target_buffer #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8,
  parameter int CTR_BITS   = 2,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] correct_pc,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [STAT_W-1:0]   STAT_MAX    = '1;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [ADDR_W-1:0]   target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  // Address fields. The low two bits address bytes within the instruction
  // and are ignored. PC bits above the tag are not stored, so PCs that
  // differ only there alias to the same entry.
  logic [INDEX_BITS-1:0] lu_idx, upd_idx;
  logic [TAG_BITS-1:0]   lu_tag, upd_tag;

  assign lu_idx  = lu_pc[INDEX_BITS+1:2];
  assign lu_tag  = lu_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign upd_idx = upd_pc[INDEX_BITS+1:2];
  assign upd_tag = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  // Lookup. This path reads the registered table only, so an update in the
  // same cycle becomes visible one cycle later.
  always_comb begin
    pred_hit    = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
    pred_taken  = pred_hit && ctr_q[lu_idx][CTR_BITS-1];
    pred_target = pred_taken ? target_q[lu_idx] : lu_pc + ADDR_W'(4);
  end

  // Resolution. A taken branch whose direction was predicted correctly
  // still mispredicts when the carried target differs from the real one.
  always_comb begin
    mispredict = upd_valid &&
                 ((upd_taken != upd_pred_taken) ||
                  (upd_taken && (upd_pred_target != upd_target)));
    correct_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
  end

  logic upd_hit;
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Table training and statistics. Reset takes priority, so an update or a
  // mispredict that arrives in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lu_valid && (stat_lookups != STAT_MAX))
        stat_lookups <= stat_lookups + STAT_W'(1);
      if (mispredict && (stat_mispredicts != STAT_MAX))
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);

      if (upd_valid) begin
        if (upd_hit) begin
          if (upd_taken) begin
            if (ctr_q[upd_idx] != CTR_MAX)
              ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_BITS'(1);
            target_q[upd_idx] <= upd_target;
          end else if (ctr_q[upd_idx] != '0) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_BITS'(1);
          end
        end else if (upd_taken) begin
          // A taken branch with no matching entry allocates a new entry,
          // or replaces the alias in that slot, as weakly taken.
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= upd_target;
          ctr_q[upd_idx]    <= CTR_WEAK_T;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer
//
// Self-checking bench for branch_target_buffer. It checks directed
// scenarios from the test plan, then randomized traffic against a
// behavioural table model. STAT_W is reduced to 4 so that counter
// saturation can be reached quickly.

module tb_branch_target_buffer;

  localparam int ADDR_W     = 32;
  localparam int INDEX_BITS = 4;
  localparam int TAG_BITS   = 8;
  localparam int CTR_BITS   = 2;
  localparam int STAT_W     = 4;
  localparam int ENTRIES    = 1 << INDEX_BITS;
  localparam int CTR_TOP    = (1 << CTR_BITS) - 1;
  localparam int CTR_HALF   = 1 << (CTR_BITS - 1);
  localparam int STAT_TOP   = (1 << STAT_W) - 1;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_pc;
  logic              pred_hit, pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid, upd_taken, upd_pred_taken;
  logic [ADDR_W-1:0] upd_pc, upd_target, upd_pred_target;
  logic              mispredict;
  logic [ADDR_W-1:0] correct_pc;
  logic [STAT_W-1:0] stat_lookups, stat_mispredicts;

  always #5 clk = ~clk;

  branch_target_buffer #(
    .ADDR_W(ADDR_W), .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS),
    .CTR_BITS(CTR_BITS), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .lu_valid(lu_valid), .lu_pc(lu_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .correct_pc(correct_pc),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int          m_lookups;
  int          m_mispred;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return (pc >> (2 + INDEX_BITS)) % (1 << TAG_BITS);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 0;
      m_tag[i]    = 0;
      m_target[i] = '0;
      m_ctr[i]    = CTR_HALF - 1;
    end
    m_lookups = 0;
    m_mispred = 0;
  endfunction

  function automatic bit exp_hit(logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit exp_taken(logic [31:0] pc);
    return exp_hit(pc) && (m_ctr[idx_of(pc)] >= CTR_HALF);
  endfunction

  function automatic logic [31:0] exp_target(logic [31:0] pc);
    logic [31:0] nxt;
    nxt = pc + 32'd4;
    return exp_taken(pc) ? m_target[idx_of(pc)] : nxt;
  endfunction

  function automatic bit exp_mispredict();
    if (!upd_valid) return 0;
    if (upd_taken != upd_pred_taken) return 1;
    return upd_taken && (upd_pred_target != upd_target);
  endfunction

  function automatic logic [31:0] exp_correct();
    logic [31:0] nxt;
    nxt = upd_pc + 32'd4;
    return upd_taken ? upd_target : nxt;
  endfunction

  function automatic void model_update();
    int i;
    i = idx_of(upd_pc);
    if (exp_hit(upd_pc)) begin
      if (upd_taken) begin
        m_ctr[i]    = (m_ctr[i] + 1 > CTR_TOP) ? CTR_TOP : m_ctr[i] + 1;
        m_target[i] = upd_target;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (upd_taken) begin
      m_valid[i]  = 1;
      m_tag[i]    = tag_of(upd_pc);
      m_target[i] = upd_target;
      m_ctr[i]    = CTR_HALF;
    end
  endfunction

  // Advance one clock edge and apply the same edge to the model. Inputs
  // change 1 time unit after the edge, so checks are made away from it.
  task automatic tick();
    bit mis;
    mis = exp_mispredict();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (lu_valid && m_lookups < STAT_TOP) m_lookups++;
      if (mis && m_mispred < STAT_TOP) m_mispred++;
      if (upd_valid) model_update();
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_lookup(input logic [31:0] pc, input logic v);
    lu_pc    = pc;
    lu_valid = v;
  endtask

  task automatic drive_update(input logic [31:0] pc, input logic taken,
                              input logic [31:0] tgt, input logic p_taken,
                              input logic [31:0] p_tgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = taken;
    upd_target      = tgt;
    upd_pred_taken  = p_taken;
    upd_pred_target = p_tgt;
  endtask

  task automatic idle_update();
    upd_valid       = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_lookup(32'h40, 1'b0);
    idle_update();
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
      n_fail++;
      $display("FAIL reset_lookup: got hit=%b taken=%b tgt=%h, want 0 0 00000044",
               pred_hit, pred_taken, pred_target);
    end
    n_checks++;
    if (stat_lookups !== 4'd0 || stat_mispredicts !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d/%0d, want 0/0", stat_lookups, stat_mispredicts);
    end
    n_checks++;
    if (mispredict !== 1'b0 || correct_pc !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_idle_resolve: got mis=%b pc=%h, want 0 00000004",
               mispredict, correct_pc);
    end
    drive_lookup(32'hFFFF_FFFC, 1'b0);
    #1;
    n_checks++;
    if (pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h, want 00000000", pred_target);
    end
  endtask

  task automatic test_allocate();
    drive_update(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    drive_lookup(32'h40, 1'b0);
    #1;
    n_checks++;
    if (mispredict !== 1'b1 || correct_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL alloc_resolve: got mis=%b pc=%h, want 1 00000100", mispredict, correct_pc);
    end
    tick();
    idle_update();
    #1;
    n_checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h100) begin
      n_fail++;
      $display("FAIL alloc_lookup: got hit=%b taken=%b tgt=%h, want 1 1 00000100",
               pred_hit, pred_taken, pred_target);
    end
    n_checks++;
    if (stat_mispredicts !== 4'd1) begin
      n_fail++;
      $display("FAIL alloc_stat: got %0d, want 1", stat_mispredicts);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      drive_update(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      tick();
    end
    idle_update();
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin
      n_fail++;
      $display("FAIL sat_top: got taken=%b tgt=%h, want 1 00000100", pred_taken, pred_target);
    end
    for (int k = 0; k < 2; k++) begin
      drive_update(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
      tick();
    end
    idle_update();
    #1;
    n_checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
      n_fail++;
      $display("FAIL sat_down2: got hit=%b taken=%b tgt=%h, want 1 0 00000044",
               pred_hit, pred_taken, pred_target);
    end
    // Two more not-taken reach the floor. One taken then gives ctr=1, which
    // is still not taken. A second taken gives ctr=2.
    for (int k = 0; k < 3; k++) begin
      drive_update(32'h40, (k == 2), 32'h100, 1'b0, 32'h44);
      tick();
    end
    idle_update();
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_floor: got taken=%b, want 0", pred_taken);
    end
    drive_update(32'h40, 1'b1, 32'h120, 1'b0, 32'h44);
    tick();
    idle_update();
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h120) begin
      n_fail++;
      $display("FAIL sat_retarget: got taken=%b tgt=%h, want 1 00000120", pred_taken, pred_target);
    end
  endtask

  task automatic test_alias();
    drive_lookup(32'h440, 1'b0);
    #1;
    n_checks++;
    if (pred_hit !== 1'b0 || pred_target !== 32'h444) begin
      n_fail++;
      $display("FAIL alias_miss: got hit=%b tgt=%h, want 0 00000444", pred_hit, pred_target);
    end
    drive_update(32'h440, 1'b1, 32'h200, 1'b0, 32'h444);
    tick();
    idle_update();
    drive_lookup(32'h40, 1'b0);
    #1;
    n_checks++;
    if (pred_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL alias_evicted: got hit=%b, want 0", pred_hit);
    end
    drive_lookup(32'h440, 1'b0);
    #1;
    n_checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      n_fail++;
      $display("FAIL alias_replaced: got hit=%b taken=%b tgt=%h, want 1 1 00000200",
               pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_same_cycle();
    drive_update(32'h80, 1'b1, 32'h300, 1'b1, 32'h300);
    drive_lookup(32'h80, 1'b1);
    #1;
    n_checks++;
    if (pred_hit !== 1'b0 || mispredict !== 1'b0 || correct_pc !== 32'h300) begin
      n_fail++;
      $display("FAIL same_cycle_old: got hit=%b mis=%b pc=%h, want 0 0 00000300",
               pred_hit, mispredict, correct_pc);
    end
    tick();
    idle_update();
    drive_lookup(32'h80, 1'b0);
    #1;
    n_checks++;
    if (pred_hit !== 1'b1 || pred_target !== 32'h300) begin
      n_fail++;
      $display("FAIL same_cycle_new: got hit=%b tgt=%h, want 1 00000300", pred_hit, pred_target);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int c = 0; c < 400; c++) begin
      pc = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 3)) << 6) |
           (32'($urandom_range(0, ENTRIES - 1)) << 2) | 32'($urandom_range(0, 3));
      drive_lookup(pc, 1'($urandom_range(0, 1)));
      pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, ENTRIES - 1)) << 2);
      if ($urandom_range(0, 3) != 0) begin
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = 1'($urandom_range(0, 1));
        upd_target      = 32'($urandom_range(0, 255)) << 2;
        upd_pred_taken  = 1'($urandom_range(0, 1));
        upd_pred_target = ($urandom_range(0, 1) != 0) ? upd_target : $urandom;
      end else begin
        idle_update();
        upd_pc = $urandom;
      end
      #1;
      n_checks++;
      if (pred_hit !== exp_hit(lu_pc) || pred_taken !== exp_taken(lu_pc) ||
          pred_target !== exp_target(lu_pc)) begin
        n_fail++;
        $display("FAIL rand_lookup pc=%h: got %b %b %h, want %b %b %h", lu_pc,
                 pred_hit, pred_taken, pred_target,
                 exp_hit(lu_pc), exp_taken(lu_pc), exp_target(lu_pc));
      end
      n_checks++;
      if (mispredict !== exp_mispredict() || correct_pc !== exp_correct()) begin
        n_fail++;
        $display("FAIL rand_resolve: got %b %h, want %b %h",
                 mispredict, correct_pc, exp_mispredict(), exp_correct());
      end
      n_checks++;
      if (int'(stat_lookups) != m_lookups || int'(stat_mispredicts) != m_mispred) begin
        n_fail++;
        $display("FAIL rand_stats: got %0d/%0d, want %0d/%0d",
                 stat_lookups, stat_mispredicts, m_lookups, m_mispred);
      end
      tick();
    end
    idle_update();
    lu_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Make sure 0x80 is present before the reset.
    drive_update(32'h80, 1'b1, 32'h300, 1'b0, 32'h84);
    tick();
    reset = 1'b1;
    drive_update(32'h80, 1'b1, 32'h500, 1'b0, 32'h84);
    drive_lookup(32'h80, 1'b1);
    #1;
    n_checks++;
    if (mispredict !== 1'b1 || correct_pc !== 32'h500) begin
      n_fail++;
      $display("FAIL reset_mid_resolve: got mis=%b pc=%h, want 1 00000500", mispredict, correct_pc);
    end
    tick();
    reset = 1'b0;
    idle_update();
    drive_lookup(32'h80, 1'b0);
    #1;
    n_checks++;
    if (pred_hit !== 1'b0 || stat_lookups !== 4'd0 || stat_mispredicts !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got hit=%b stats=%0d/%0d, want 0 0/0",
               pred_hit, stat_lookups, stat_mispredicts);
    end
    lu_valid = 1'b1;
    for (int k = 0; k < 14; k++) tick();
    n_checks++;
    if (stat_lookups !== 4'd14) begin
      n_fail++;
      $display("FAIL stat_count: got %0d, want 14", stat_lookups);
    end
    for (int k = 14; k < (1 << STAT_W) + 5; k++) tick();
    n_checks++;
    if (stat_lookups !== 4'd15 || int'(stat_lookups) != m_lookups) begin
      n_fail++;
      $display("FAIL stat_saturate: got %0d, want 15", stat_lookups);
    end
    lu_valid = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    drive_lookup('0, 1'b0);
    idle_update();
    model_reset();
    test_reset();
    test_allocate();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
